decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/rv_pkg.sv | 54 +++++
 rtl/rv_decode.sv | 124 ++++++++++++
 rtl/decode_stage.sv | 117 +++++++++++
 tb/tb_decode_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// RV32I decode definitions shared by the decode stage and its decoder.
// Holds opcode constants, ALU/branch op encodings and the decoded bundle.
package rv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SR  = 3'b101;

    localparam logic [2:0] NEVER_BRANCH = 3'b010;
    localparam logic [2:0] BR_RSV       = 3'b011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  alu_op;
        logic        alu_sub;
        logic        alu_arith_shift;
        logic [2:0]  branch_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_load;
        logic        is_store;
        logic        is_lui;
        logic        is_auipc;
        logic        reg_write;
        logic        illegal;
    } dec_t;

    function automatic dec_t dec_reset();
        dec_t d;
        d           = '0;
        d.branch_op = NEVER_BRANCH;
        return d;
    endfunction

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I decoder: instruction word to decoded bundle.
// Illegal encodings still produce a bundle, with side effects suppressed.
module rv_decode
    import rv_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output dec_t        dec_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        wr;
    logic        ill;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        dec_o           = '0;
        dec_o.pc        = pc_i;
        dec_o.branch_op = NEVER_BRANCH;
        dec_o.rs1       = instr_i[19:15];
        dec_o.rs2       = instr_i[24:20];
        dec_o.rd        = instr_i[11:7];
        wr              = 1'b0;
        ill             = 1'b0;
        unique case (opc)
            OPC_OP: begin
                dec_o.alu_op          = f3;
                dec_o.alu_sub         = (f3 == ALU_ADD) & f7[5];
                dec_o.alu_arith_shift = (f3 == ALU_SR) & f7[5];
                wr                    = 1'b1;
                ill = !((f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == ALU_ADD) || (f3 == ALU_SR))));
            end
            OPC_OPIMM: begin
                dec_o.alu_op  = f3;
                dec_o.use_imm = 1'b1;
                wr            = 1'b1;
                // Shift-immediates carry only a shamt; funct7 is an opcode extension.
                if (f3 == ALU_SLL) begin
                    dec_o.imm = {27'b0, instr_i[24:20]};
                    ill       = (f7 != F7_BASE);
                end else if (f3 == ALU_SR) begin
                    dec_o.imm             = {27'b0, instr_i[24:20]};
                    dec_o.alu_arith_shift = f7[5];
                    ill = !((f7 == F7_BASE) || (f7 == F7_ALT));
                end else begin
                    dec_o.imm = imm_i;
                end
            end
            OPC_LOAD: begin
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_i;
                dec_o.is_load = 1'b1;
                wr            = 1'b1;
            end
            OPC_STORE: begin
                dec_o.use_imm  = 1'b1;
                dec_o.imm      = imm_s;
                dec_o.is_store = 1'b1;
            end
            OPC_LUI: begin
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_u;
                dec_o.is_lui  = 1'b1;
                wr            = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.use_imm  = 1'b1;
                dec_o.imm      = imm_u;
                dec_o.is_auipc = 1'b1;
                wr             = 1'b1;
            end
            OPC_JAL: begin
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_j;
                dec_o.is_jal  = 1'b1;
                wr            = 1'b1;
            end
            OPC_JALR: begin
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_i;
                dec_o.is_jalr = 1'b1;
                wr            = 1'b1;
            end
            OPC_BRANCH: begin
                dec_o.branch_op = f3;
                dec_o.imm       = imm_b;
                dec_o.is_branch = 1'b1;
                ill = (f3 == NEVER_BRANCH) || (f3 == BR_RSV);
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec_o.branch_op = NEVER_BRANCH;
            dec_o.is_branch = 1'b0;
            dec_o.is_jal    = 1'b0;
            dec_o.is_jalr   = 1'b0;
            dec_o.is_load   = 1'b0;
            dec_o.is_store  = 1'b0;
            dec_o.is_lui    = 1'b0;
            dec_o.is_auipc  = 1'b0;
        end
        dec_o.reg_write = wr & ~ill & (dec_o.rd != 5'd0);
        dec_o.illegal   = ill;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decoder followed by an output register with one
// skid entry, so o_ready is registered and independent of i_ready.
module decode_stage
    import rv_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [2:0]  o_alu_op,
    output logic        o_alu_sub,
    output logic        o_alu_arith_shift,
    output logic [2:0]  o_branch_op,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [31:0] o_imm,
    output logic        o_use_imm,
    output logic        o_is_branch,
    output logic        o_is_jal,
    output logic        o_is_jalr,
    output logic        o_is_load,
    output logic        o_is_store,
    output logic        o_is_lui,
    output logic        o_is_auipc,
    output logic        o_reg_write,
    output logic        o_illegal
);

    dec_t dec;
    dec_t out_q, out_d;
    dec_t skid_q, skid_d;
    logic out_vld_q, out_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic rdy_q, rdy_d;
    logic acc;
    logic xfer;

    rv_decode u_dec (
        .instr_i (i_instr),
        .pc_i    (i_pc),
        .dec_o   (dec)
    );

    assign acc  = i_valid & rdy_q;
    assign xfer = out_vld_q & i_ready;

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (i_flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || xfer) begin
            // rdy_q is low whenever the skid is full, so acc cannot collide here
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = acc;
                if (acc) out_d = dec;
            end
        end else if (acc) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q      <= dec_reset();
            skid_q     <= dec_reset();
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign o_ready           = rdy_q;
    assign o_valid           = out_vld_q;
    assign o_pc              = out_q.pc;
    assign o_alu_op          = out_q.alu_op;
    assign o_alu_sub         = out_q.alu_sub;
    assign o_alu_arith_shift = out_q.alu_arith_shift;
    assign o_branch_op       = out_q.branch_op;
    assign o_rs1             = out_q.rs1;
    assign o_rs2             = out_q.rs2;
    assign o_rd              = out_q.rd;
    assign o_imm             = out_q.imm;
    assign o_use_imm         = out_q.use_imm;
    assign o_is_branch       = out_q.is_branch;
    assign o_is_jal          = out_q.is_jal;
    assign o_is_jalr         = out_q.is_jalr;
    assign o_is_load         = out_q.is_load;
    assign o_is_store        = out_q.is_store;
    assign o_is_lui          = out_q.is_lui;
    assign o_is_auipc        = out_q.is_auipc;
    assign o_reg_write       = out_q.reg_write;
    assign o_illegal         = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: FIFO-style reference model plus
// directed literal checks on known encodings and handshake corner cases.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_in;
    logic        o_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        o_valid;
    logic        rdy_in;
    logic [31:0] o_pc;
    logic [2:0]  o_alu_op;
    logic        o_alu_sub;
    logic        o_alu_arith_shift;
    logic [2:0]  o_branch_op;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [4:0]  o_rd;
    logic [31:0] o_imm;
    logic        o_use_imm;
    logic        o_is_branch;
    logic        o_is_jal;
    logic        o_is_jalr;
    logic        o_is_load;
    logic        o_is_store;
    logic        o_is_lui;
    logic        o_is_auipc;
    logic        o_reg_write;
    logic        o_illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_valid           (vld_in),
        .o_ready           (o_ready),
        .i_instr           (instr),
        .i_pc              (pc),
        .i_flush           (flush),
        .o_valid           (o_valid),
        .i_ready           (rdy_in),
        .o_pc              (o_pc),
        .o_alu_op          (o_alu_op),
        .o_alu_sub         (o_alu_sub),
        .o_alu_arith_shift (o_alu_arith_shift),
        .o_branch_op       (o_branch_op),
        .o_rs1             (o_rs1),
        .o_rs2             (o_rs2),
        .o_rd              (o_rd),
        .o_imm             (o_imm),
        .o_use_imm         (o_use_imm),
        .o_is_branch       (o_is_branch),
        .o_is_jal          (o_is_jal),
        .o_is_jalr         (o_is_jalr),
        .o_is_load         (o_is_load),
        .o_is_store        (o_is_store),
        .o_is_lui          (o_is_lui),
        .o_is_auipc        (o_is_auipc),
        .o_reg_write       (o_reg_write),
        .o_illegal         (o_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  alu;
        logic [2:0]  bop;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        sub;
        logic        ash;
        logic        use_imm;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        ld;
        logic        st;
        logic        lui;
        logic        auipc;
        logic        wr;
        logic        ill;
    } exp_t;

    exp_t q[$];
    bit   mrdy = 1'b0;
    bit   go = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] shamt;
        bit writes;
        f3 = ins[14:12];
        f7 = ins[31:25];
        shamt = {27'b0, ins[24:20]};
        e = '{default: '0};
        e.pc  = p;
        e.bop = 3'b010;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        writes = 1'b0;
        case (ins[6:0])
            7'h33: begin
                e.alu = f3;
                e.sub = (f3 == 3'd0) && f7 == 7'h20;
                e.ash = (f3 == 3'd5) && f7 == 7'h20;
                writes = 1'b1;
                e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h13: begin
                e.alu = f3;
                e.use_imm = 1'b1;
                writes = 1'b1;
                if (f3 == 3'd1) begin
                    e.imm = shamt;
                    e.ill = f7 != 7'h00;
                end else if (f3 == 3'd5) begin
                    e.imm = shamt;
                    e.ash = f7 == 7'h20;
                    e.ill = !(f7 == 7'h00 || f7 == 7'h20);
                end else begin
                    e.imm = 32'(signed'(ins[31:20]));
                end
            end
            7'h03: begin
                e.use_imm = 1'b1; e.ld = 1'b1; writes = 1'b1;
                e.imm = 32'(signed'(ins[31:20]));
            end
            7'h23: begin
                e.use_imm = 1'b1; e.st = 1'b1;
                e.imm = 32'(signed'({ins[31:25], ins[11:7]}));
            end
            7'h37: begin
                e.use_imm = 1'b1; e.lui = 1'b1; writes = 1'b1;
                e.imm = ins & 32'hFFFFF000;
            end
            7'h17: begin
                e.use_imm = 1'b1; e.auipc = 1'b1; writes = 1'b1;
                e.imm = ins & 32'hFFFFF000;
            end
            7'h6F: begin
                e.use_imm = 1'b1; e.jal = 1'b1; writes = 1'b1;
                e.imm = 32'(signed'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'h67: begin
                e.use_imm = 1'b1; e.jalr = 1'b1; writes = 1'b1;
                e.imm = 32'(signed'(ins[31:20]));
            end
            7'h63: begin
                e.br = 1'b1; e.bop = f3;
                e.imm = 32'(signed'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                e.ill = (f3 == 3'd2 || f3 == 3'd3);
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.bop = 3'b010;
            e.br = 0; e.jal = 0; e.jalr = 0; e.ld = 0;
            e.st = 0; e.lui = 0; e.auipc = 0;
            writes = 1'b0;
        end
        e.wr = writes && (e.rd != 5'd0);
        return e;
    endfunction

    // Reference: a two-entry in-order queue between accept and transfer.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            mrdy = 1'b0;
        end else if (flush) begin
            q.delete();
            mrdy = 1'b1;
        end else begin
            if (q.size() > 0 && rdy_in) void'(q.pop_front());
            if (vld_in && mrdy) q.push_back(model(instr, pc));
            mrdy = q.size() < 2;
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("cmp_ready", {31'b0, o_ready}, {31'b0, mrdy});
            chk("cmp_valid", {31'b0, o_valid}, {31'b0, q.size() > 0});
            if (q.size() > 0 && o_valid) begin
                chk("cmp_pc", o_pc, q[0].pc);
                chk("cmp_imm", o_imm, q[0].imm);
                chk("cmp_alu", {29'b0, o_alu_op}, {29'b0, q[0].alu});
                chk("cmp_bop", {29'b0, o_branch_op}, {29'b0, q[0].bop});
                chk("cmp_regs", {17'b0, o_rs1, o_rs2, o_rd},
                    {17'b0, q[0].rs1, q[0].rs2, q[0].rd});
                chk("cmp_flags",
                    {19'b0, o_alu_sub, o_alu_arith_shift, o_use_imm, o_is_branch,
                     o_is_jal, o_is_jalr, o_is_load, o_is_store, o_is_lui,
                     o_is_auipc, o_reg_write, o_illegal, 1'b0},
                    {19'b0, q[0].sub, q[0].ash, q[0].use_imm, q[0].br,
                     q[0].jal, q[0].jalr, q[0].ld, q[0].st, q[0].lui,
                     q[0].auipc, q[0].wr, q[0].ill, 1'b0});
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] ins,
                       input logic [31:0] p, input logic r, input logic f);
        vld_in = v;
        instr  = ins;
        pc     = p;
        rdy_in = r;
        flush  = f;
        @(negedge clk);
    endtask

    logic [31:0] tbl [16];

    initial begin
        tbl = '{32'h00812383, 32'hFE712E23, 32'h12345137, 32'h00001217,
                32'h008000EF, 32'h00008067, 32'h02208033, 32'h40109093,
                32'h00002063, 32'h00208033, 32'hFFF34293, 32'h00435293,
                32'h4020D1B3, 32'h0020F1B3, 32'h402091B3, 32'h00000073};
        rst = 1'b1; vld_in = 1'b0; instr = '0; pc = '0;
        rdy_in = 1'b1; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        go = 1'b1;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_ready", {31'b0, o_ready}, 32'd0);
        chk("rst_imm", o_imm, 32'd0);
        chk("rst_bop", {29'b0, o_branch_op}, 32'd2);
        chk("rst_pc", o_pc, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, o_ready}, 32'd1);

        cyc(1, 32'h402081B3, 32'h100, 1, 0);
        chk("sub_alu", {29'b0, o_alu_op}, 32'd0);
        chk("sub_sub", {31'b0, o_alu_sub}, 32'd1);
        chk("sub_regs", {17'b0, o_rs1, o_rs2, o_rd}, {17'b0, 5'd1, 5'd2, 5'd3});
        chk("sub_useimm", {31'b0, o_use_imm}, 32'd0);
        chk("sub_wr", {31'b0, o_reg_write}, 32'd1);
        cyc(1, 32'h40435293, 32'h104, 1, 0);
        chk("srai_alu", {29'b0, o_alu_op}, 32'd5);
        chk("srai_ash", {31'b0, o_alu_arith_shift}, 32'd1);
        chk("srai_imm", o_imm, 32'd4);
        chk("srai_useimm", {31'b0, o_use_imm}, 32'd1);
        chk("srai_rd", {27'b0, o_rd}, 32'd5);
        cyc(1, 32'hFE208EE3, 32'h108, 1, 0);
        chk("beq_br", {31'b0, o_is_branch}, 32'd1);
        chk("beq_bop", {29'b0, o_branch_op}, 32'd0);
        chk("beq_imm", o_imm, 32'hFFFFFFFC);
        chk("beq_wr", {31'b0, o_reg_write}, 32'd0);
        cyc(1, 32'h00000000, 32'h10C, 1, 0);
        chk("zero_ill", {31'b0, o_illegal}, 32'd1);
        chk("zero_wr", {31'b0, o_reg_write}, 32'd0);
        chk("zero_bop", {29'b0, o_branch_op}, 32'd2);
        cyc(0, 0, 0, 1, 0);

        foreach (tbl[i]) cyc(1, tbl[i], 32'h1000 + 4 * i, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Back-to-back with a two-cycle downstream stall.
        cyc(1, 32'h00100093, 32'h200, 0, 0);
        chk("stall_c1_pc", o_pc, 32'h200);
        cyc(1, 32'h12345137, 32'h204, 0, 0);
        chk("stall_c2_pc", o_pc, 32'h200);
        chk("stall_c2_rdy", {31'b0, o_ready}, 32'd0);
        cyc(1, 32'h0020F1B3, 32'h208, 1, 0);
        chk("stall_c3_pc", o_pc, 32'h204);
        chk("stall_c3_rdy", {31'b0, o_ready}, 32'd1);
        cyc(1, 32'h0020F1B3, 32'h208, 1, 0);
        chk("stall_c4_pc", o_pc, 32'h208);
        cyc(0, 0, 0, 1, 0);
        chk("stall_drained", {31'b0, o_valid}, 32'd0);

        // Flush with both entries occupied, then flush against an accept.
        cyc(1, 32'h00100093, 32'h300, 0, 0);
        cyc(1, 32'h12345137, 32'h304, 0, 0);
        cyc(1, 32'h0020F1B3, 32'h308, 0, 1);
        chk("flush_valid", {31'b0, o_valid}, 32'd0);
        chk("flush_ready", {31'b0, o_ready}, 32'd1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("flush_stale", {31'b0, o_valid}, 32'd0);
        cyc(1, 32'h00100093, 32'h400, 1, 1);
        chk("flush_acc", {31'b0, o_valid}, 32'd0);

        // Reset while stalled with both entries occupied.
        cyc(1, 32'h00100093, 32'h500, 0, 0);
        cyc(1, 32'h12345137, 32'h504, 0, 0);
        rst = 1'b1;
        cyc(1, 32'h0020F1B3, 32'h508, 1, 0);
        chk("midrst_valid", {31'b0, o_valid}, 32'd0);
        chk("midrst_ready", {31'b0, o_ready}, 32'd0);
        rst = 1'b0;
        cyc(0, 0, 0, 1, 0);
        chk("midrst_ready1", {31'b0, o_ready}, 32'd1);
        cyc(0, 0, 0, 1, 0);
        chk("midrst_stale", {31'b0, o_valid}, 32'd0);

        // Random handshakes over the table; instruction held until accepted.
        begin
            int idx = 0;
            for (int c = 0; c < 120; c++) begin
                logic v;
                logic r;
                v = ($urandom_range(3) != 0);
                r = ($urandom_range(2) != 0);
                vld_in = v;
                instr  = tbl[idx % 16];
                pc     = 32'h2000 + 4 * idx;
                rdy_in = r;
                flush  = 1'b0;
                if (v && mrdy) idx++;
                @(negedge clk);
            end
        end
        repeat (4) cyc(0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
